// File: rtl/alu_z_stage.sv
// alu_z_stage: sequences one ALU op per start, waits its latency, captures the result into ZHI/ZLO and holds it until acknowledged
// Ports: clk, reset (sync, active-high); start, ctrl_signal (one-hot op select), alu_result (2*BITS) in;
//        busy, z_valid, zhi_out, zlo_out, zero_flag, neg_flag, op_error out; z_ack in (consumer took Z)
module alu_z_stage #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 12,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SIG_COUNT-1:0] ctrl_signal,
    input  logic [2*BITS-1:0]    alu_result,
    output logic                 busy,
    output logic                 z_valid,
    input  logic                 z_ack,
    output logic [BITS-1:0]      zhi_out,
    output logic [BITS-1:0]      zlo_out,
    output logic                 zero_flag,
    output logic                 neg_flag,
    output logic                 op_error
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    localparam logic [5:0] MUL_M1 = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_M1 = 6'(DIV_LAT - 1);
    state_t          r_state, w_next;
    logic [5:0]      r_cnt;
    logic            r_mul, r_div;
    logic [BITS-1:0] r_zhi, r_zlo;
    logic            r_zero, r_neg, r_err;
    logic            w_open, w_acc, w_rej, w_cap;
    logic [5:0]      w_load;
    logic [BITS-1:0] w_zhi, w_zlo;
    assign w_open  = (r_state == IDLE) || (r_state == HOLD && z_ack);
    assign w_acc   = start && w_open && $onehot(ctrl_signal);
    assign w_rej   = start && w_open && !$onehot(ctrl_signal);
    assign w_cap   = (r_state == WAIT) && (r_cnt == 6'd0);
    // counter holds L-1 so that capture lands on the L-th edge after acceptance
    assign w_load  = ctrl_signal[2] ? MUL_M1 : ctrl_signal[3] ? DIV_M1 : 6'd0;
    assign w_zhi   = (r_mul || r_div) ? alu_result[2*BITS-1:BITS] : '0;
    assign w_zlo   = alu_result[BITS-1:0];
    assign zhi_out   = r_zhi;
    assign zlo_out   = r_zlo;
    assign zero_flag = r_zero;
    assign neg_flag  = r_neg;
    assign op_error  = r_err;
    always_comb begin
        w_next  = r_state;
        busy    = (r_state == WAIT);
        z_valid = (r_state == HOLD);
        case (r_state)
            IDLE:    w_next = w_acc ? WAIT : IDLE;
            WAIT:    w_next = w_cap ? HOLD : WAIT;
            HOLD:    w_next = z_ack ? (w_acc ? WAIT : IDLE) : HOLD;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mul   <= 1'b0;
            r_div   <= 1'b0;
            r_zhi   <= '0;
            r_zlo   <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_rej;
            if (w_acc) begin
                r_cnt <= w_load;
                r_mul <= ctrl_signal[2];
                r_div <= ctrl_signal[3];
            end else if (r_state == WAIT && r_cnt != 6'd0) begin
                r_cnt <= r_cnt - 6'd1;
            end
            if (w_cap) begin
                r_zhi  <= w_zhi;
                r_zlo  <= w_zlo;
                r_zero <= (w_zhi == '0) && (w_zlo == '0);
                // divide reports the quotient sign, which lives in the low word
                r_neg  <= r_mul ? w_zhi[BITS-1] : w_zlo[BITS-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_z_stage.sv
// tb_alu_z_stage: directed stimulus with a behavioural reference model checked every cycle
module tb_alu_z_stage;
    localparam int BITS = 32, SIG_COUNT = 12, MUL_LAT = 4, DIV_LAT = 32;
    logic clk = 0, reset = 1, start = 0, z_ack = 0;
    logic [SIG_COUNT-1:0] ctrl_signal = '0;
    logic [2*BITS-1:0] alu_result = '0;
    logic busy, z_valid, zero_flag, neg_flag, op_error;
    logic [BITS-1:0] zhi_out, zlo_out;
    int checks = 0, failures = 0;
    alu_z_stage #(.BITS(BITS), .SIG_COUNT(SIG_COUNT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .ctrl_signal(ctrl_signal), .alu_result(alu_result),
        .busy(busy), .z_valid(z_valid), .z_ack(z_ack), .zhi_out(zhi_out), .zlo_out(zlo_out),
        .zero_flag(zero_flag), .neg_flag(neg_flag), .op_error(op_error));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // reference model: remaining-cycle count and op kind, captured result as plain values
    int m_rem = 0, m_kind = 0;
    bit m_busy = 0, m_valid = 0, m_err = 0, m_zero = 0, m_neg = 0;
    logic [BITS-1:0] m_zhi = '0, m_zlo = '0;
    always @(posedge clk) begin
        if (reset) begin
            m_rem = 0; m_busy = 0; m_valid = 0; m_err = 0; m_zero = 0; m_neg = 0; m_zhi = '0; m_zlo = '0;
        end else begin
            bit can;
            can = (!m_busy && !m_valid) || (m_valid && z_ack);
            m_err = 0;
            if (m_busy) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_zlo = alu_result[31:0];
                    m_zhi = (m_kind != 0) ? alu_result[63:32] : 32'h0;
                    m_zero = ({m_zhi, m_zlo} == 64'h0);
                    m_neg = (m_kind == 1) ? alu_result[63] : alu_result[31];
                    m_busy = 0;
                    m_valid = 1;
                end
            end else begin
                if (m_valid && z_ack) m_valid = 0;
                if (start && can) begin
                    if ($countones(ctrl_signal) == 1) begin
                        m_busy = 1;
                        m_kind = ctrl_signal[2] ? 1 : ctrl_signal[3] ? 2 : 0;
                        m_rem = (m_kind == 1) ? MUL_LAT : (m_kind == 2) ? DIV_LAT : 1;
                    end else m_err = 1;
                end
            end
        end
    end
    initial forever begin
        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("z_valid", 64'(z_valid), 64'(m_valid));
        chk("op_error", 64'(op_error), 64'(m_err));
        chk("zhi", 64'(zhi_out), 64'(m_zhi));
        chk("zlo", 64'(zlo_out), 64'(m_zlo));
        chk("zero_flag", 64'(zero_flag), 64'(m_zero));
        chk("neg_flag", 64'(neg_flag), 64'(m_neg));
    end
    task automatic op(input logic [11:0] c, input logic [63:0] r, input int lat, input bit inj);
        int n = 0;
        @(negedge clk);
        ctrl_signal = c; alu_result = r; start = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = inj && (i == 1);
            if (z_valid) break;
            n++;
        end
        start = 0;
        chk("latency", 64'(n), 64'(lat));
    endtask
    task automatic ack();
        @(negedge clk); z_ack = 1;
        @(negedge clk); z_ack = 0;
    endtask
    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_zlo", 64'(zlo_out), 0);
        op(12'h001, 64'h7, 1, 0);
        chk("add_zlo", 64'(zlo_out), 64'h7);
        chk("add_zhi", 64'(zhi_out), 0);
        ack();
        chk("add_ackvalid", 64'(z_valid), 0);
        chk("add_held", 64'(zlo_out), 64'h7);
        op(12'h004, 64'hFFFF_FFFF_FFFF_FFFA, 4, 1);
        chk("mul_zhi", 64'(zhi_out), 64'hFFFF_FFFF);
        chk("mul_zlo", 64'(zlo_out), 64'hFFFF_FFFA);
        chk("mul_neg", 64'(neg_flag), 1);
        ack();
        op(12'h008, 64'h0000_0001_0000_0000, 32, 0);
        chk("div_zhi", 64'(zhi_out), 1);
        chk("div_zlo", 64'(zlo_out), 0);
        chk("div_zero", 64'(zero_flag), 0);
        chk("div_neg", 64'(neg_flag), 0);
        ack();
        @(negedge clk); ctrl_signal = 12'h003; start = 1;
        @(negedge clk); start = 0;
        chk("ill1_err", 64'(op_error), 1);
        chk("ill1_busy", 64'(busy), 0);
        @(negedge clk);
        chk("ill1_pulse", 64'(op_error), 0);
        ctrl_signal = 12'h000; start = 1;
        @(negedge clk); start = 0;
        chk("ill2_err", 64'(op_error), 1);
        @(negedge clk);
        chk("ill2_pulse", 64'(op_error), 0);
        op(12'h001, 64'h8000_0005, 1, 0);
        chk("addneg_neg", 64'(neg_flag), 1);
        @(negedge clk); z_ack = 1; start = 1; ctrl_signal = 12'h100; alu_result = 64'hABCD_0000_0000_0000;
        @(negedge clk); z_ack = 0; start = 0;
        chk("b2b_busy", 64'(busy), 1);
        chk("b2b_valid", 64'(z_valid), 0);
        @(negedge clk);
        chk("b2b_cap", 64'(z_valid), 1);
        chk("b2b_zero", 64'(zero_flag), 1);
        chk("b2b_zhi", 64'(zhi_out), 0);
        ack();
        op(12'h010, 64'h1234, 1, 0);
        ack();
        @(negedge clk); ctrl_signal = 12'h004; alu_result = 64'h55; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        chk("rmid_busy", 64'(busy), 0);
        chk("rmid_valid", 64'(z_valid), 0);
        chk("rmid_zlo", 64'(zlo_out), 0);
        repeat (8) @(negedge clk);
        chk("rmid_nocap", 64'(z_valid), 0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
